// File: rtl/i960_bus_pkg.sv
// Shared i960 Sx bus definitions. The state encoding is also used by the address-decode/ready controller.
package i960_bus_pkg;

  typedef enum logic [1:0] {
    BUS_UNKNOWN = 2'd0,
    BUS_TI      = 2'd1,
    BUS_T1      = 2'd2,
    BUS_T2      = 2'd3
  } bus_state_t;

  localparam logic [1:0] AREA_ROM     = 2'b00;
  localparam logic [1:0] AREA_RAM     = 2'b01;
  localparam int         AREA_MFP_BIT = 31;

  // Bursts stop at the 16-byte line end, so the word count is clipped to the words left in the line.
  function automatic logic [2:0] calc_nwords(input logic [1:0] len, input logic [1:0] word_idx);
    logic [2:0] want;
    logic [2:0] room;
    want = {1'b0, len} + 3'd1;
    room = 3'd4 - {1'b0, word_idx};
    return (want < room) ? want : room;
  endfunction

endpackage

// File: rtl/i960_wait_timer.sv
// Per-T2 wait-state counter. tc flags the final permitted wait, so the abort lands on the TIMEOUT-th waiting PCLK edge.
module i960_wait_timer #(
  parameter int TIMEOUT = 255
) (
  input  logic clk2,
  input  logic reset_async_n,
  input  logic clr,
  input  logic inc,
  output logic tc
);

  localparam logic [7:0] LAST_WAIT = 8'(TIMEOUT - 1);

  logic [7:0] cnt;

  always_ff @(posedge clk2 or negedge reset_async_n) begin
    if (!reset_async_n) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (inc) begin
      cnt <= cnt + 8'd1;
    end
  end

  assign tc = (cnt == LAST_WAIT);

endmodule

// File: rtl/i960_bus_master.sv
// i960 Sx local-bus initiator: single and burst (up to 4 words) read/write, Ti/T1/T2 sequencing on PCLK edges.
// Requests are accepted in Ti after IDLE_MIN idle PCLKs; each T2 waits on ready_n and aborts after TIMEOUT PCLKs.
module i960_bus_master
  import i960_bus_pkg::*;
#(
  parameter int TIMEOUT  = 255,
  parameter int IDLE_MIN = 1
) (
  input  logic        clk2,
  input  logic        reset_async_n,
  output logic        pclk,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [31:0] req_addr,
  input  logic [1:0]  req_len,
  input  logic [3:0]  req_be_n,
  input  logic [31:0] wr_data,
  output logic        wr_take,
  output logic [31:0] rd_data,
  output logic        rd_valid,
  output logic        done,
  output logic        done_err,
  output logic [2:0]  done_cnt,
  output logic [31:0] ad_out,
  output logic        ad_oe,
  input  logic [31:0] ad_in,
  output logic [3:0]  be_n,
  output logic        as_n,
  output logic        den_n,
  output logic        w_rn,
  output logic        dt_rn,
  output logic        blast_n,
  output logic        lock_n,
  output logic        inta_n,
  input  logic        ready_n
);

  localparam logic [8:0] IDLE_NEED = 9'(IDLE_MIN);

  bus_state_t  state;
  logic        write_q;
  logic [31:0] addr_q;
  logic [2:0]  nwords;
  logic [2:0]  word_cnt;
  logic [7:0]  idle_cnt;
  logic [7:0]  idle_nxt;
  logic [2:0]  req_nwords;
  logic        wait_tc;
  logic        t2_edge;
  logic        word_ack;
  logic        last_ack;
  logic        abort;
  logic        xfer_end;
  logic        unused_addr_lsb;

  assign unused_addr_lsb = ^req_addr[1:0];

  assign req_nwords = calc_nwords(req_len, req_addr[3:2]);
  assign t2_edge    = pclk && (state == BUS_T2);
  assign word_ack   = t2_edge && !ready_n;
  assign last_ack   = word_ack && ((word_cnt + 3'd1) == nwords);
  assign abort      = t2_edge && ready_n && wait_tc;
  assign xfer_end   = last_ack || abort;
  assign idle_nxt   = (idle_cnt == 8'hFF) ? idle_cnt : idle_cnt + 8'd1;

  // Write data is muxed straight from the requester: the next word arrives between PCLK edges after wr_take.
  assign ad_out = (state == BUS_T2 && write_q) ? wr_data : addr_q;
  assign lock_n = 1'b1;
  assign inta_n = 1'b1;

  i960_wait_timer #(.TIMEOUT(TIMEOUT)) u_wait_timer (
    .clk2          (clk2),
    .reset_async_n (reset_async_n),
    .clr           ((state != BUS_T2) || word_ack || abort),
    .inc           (t2_edge && ready_n),
    .tc            (wait_tc)
  );

  always_ff @(posedge clk2 or negedge reset_async_n) begin
    if (!reset_async_n) begin
      state     <= BUS_TI;
      pclk      <= 1'b0;
      req_ready <= 1'b0;
      write_q   <= 1'b0;
      addr_q    <= '0;
      nwords    <= '0;
      word_cnt  <= '0;
      idle_cnt  <= '0;
      as_n      <= 1'b1;
      den_n     <= 1'b1;
      blast_n   <= 1'b1;
      w_rn      <= 1'b0;
      dt_rn     <= 1'b0;
      ad_oe     <= 1'b0;
      be_n      <= 4'hF;
      rd_data   <= '0;
      rd_valid  <= 1'b0;
      wr_take   <= 1'b0;
      done      <= 1'b0;
      done_err  <= 1'b0;
      done_cnt  <= '0;
    end else begin
      pclk     <= ~pclk;
      rd_valid <= 1'b0;
      wr_take  <= 1'b0;
      done     <= 1'b0;
      if (pclk) begin
        case (state)
          BUS_TI: begin
            if (req_valid && req_ready) begin
              state     <= BUS_T1;
              req_ready <= 1'b0;
              idle_cnt  <= '0;
              write_q   <= req_write;
              addr_q    <= {req_addr[31:2], 2'b00};
              nwords    <= req_nwords;
              word_cnt  <= '0;
              as_n      <= 1'b0;
              ad_oe     <= 1'b1;
              w_rn      <= req_write;
              dt_rn     <= req_write;
              be_n      <= req_be_n;
              blast_n   <= (req_nwords != 3'd1);
            end else begin
              idle_cnt  <= idle_nxt;
              req_ready <= ({1'b0, idle_nxt} + 9'd1) >= IDLE_NEED;
            end
          end
          BUS_T1: begin
            state   <= BUS_T2;
            as_n    <= 1'b1;
            den_n   <= 1'b0;
            ad_oe   <= write_q;
            blast_n <= (nwords != 3'd1);
          end
          BUS_T2: begin
            if (word_ack) begin
              word_cnt <= word_cnt + 3'd1;
              if (write_q) begin
                wr_take <= 1'b1;
              end else begin
                rd_data  <= ad_in;
                rd_valid <= 1'b1;
              end
              if (!last_ack) begin
                addr_q[3:2] <= addr_q[3:2] + 2'd1;
                blast_n     <= !((word_cnt + 3'd2) == nwords);
              end
            end
            if (xfer_end) begin
              state     <= BUS_TI;
              den_n     <= 1'b1;
              blast_n   <= 1'b1;
              ad_oe     <= 1'b0;
              done      <= 1'b1;
              done_err  <= abort;
              done_cnt  <= last_ack ? nwords : word_cnt;
              idle_cnt  <= '0;
              req_ready <= 9'd1 >= IDLE_NEED;
            end
          end
          default: state <= BUS_TI;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_i960_bus_master.sv
// Directed bench for i960_bus_master: table of transactions plus hand-written reset sequences.
module tb_i960_bus_master;

  logic        clk2 = 1'b0;
  logic        reset_async_n;
  logic        pclk;
  logic        req_valid;
  logic        req_ready;
  logic        req_write;
  logic [31:0] req_addr;
  logic [1:0]  req_len;
  logic [3:0]  req_be_n;
  logic [31:0] wr_data;
  logic        wr_take;
  logic [31:0] rd_data;
  logic        rd_valid;
  logic        done;
  logic        done_err;
  logic [2:0]  done_cnt;
  logic [31:0] ad_out;
  logic        ad_oe;
  logic [31:0] ad_in;
  logic [3:0]  be_n;
  logic        as_n;
  logic        den_n;
  logic        w_rn;
  logic        dt_rn;
  logic        blast_n;
  logic        lock_n;
  logic        inta_n;
  logic        ready_n;

  always #5 clk2 = ~clk2;

  i960_bus_master #(.TIMEOUT(4), .IDLE_MIN(1)) dut (
    .clk2(clk2), .reset_async_n(reset_async_n), .pclk(pclk),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_addr(req_addr), .req_len(req_len), .req_be_n(req_be_n),
    .wr_data(wr_data), .wr_take(wr_take), .rd_data(rd_data), .rd_valid(rd_valid),
    .done(done), .done_err(done_err), .done_cnt(done_cnt),
    .ad_out(ad_out), .ad_oe(ad_oe), .ad_in(ad_in), .be_n(be_n),
    .as_n(as_n), .den_n(den_n), .w_rn(w_rn), .dt_rn(dt_rn), .blast_n(blast_n),
    .lock_n(lock_n), .inta_n(inta_n), .ready_n(ready_n)
  );

  typedef struct {
    logic        wr;
    logic [31:0] addr;
    logic [1:0]  len;
    logic [3:0]  be;
    int          waits;      // ready_n high PCLKs per word before going low
    logic [2:0]  exp_cnt;
    logic        exp_err;
    int          exp_edges;  // clk2 edges from acceptance to the done edge
    int          exp_aslow;
    int          exp_blast;
    int          exp_pulses;
  } vec_t;

  vec_t vecs[7];
  int   checks = 0;
  int   errors = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, "_ctl"}, 64'({as_n, den_n, blast_n, w_rn, dt_rn, ad_oe, be_n, lock_n, inta_n}),
          64'(13'b1_1_1_0_0_0_1111_1_1));
    check({tag, "_pulse"}, 64'({pclk, req_ready, rd_valid, wr_take, done, done_err, done_cnt}), 64'(0));
    check({tag, "_data"}, {ad_out, rd_data}, 64'(0));
  endtask

  task automatic run_txn(input vec_t v, input int vi);
    int          edges, aslow, blast, pulses, wait_left, widx, rdk, guard;
    logic        acc, acc_next, fin, t1_ok, data_ok, lock_ok, derr;
    logic [2:0]  dcnt;
    logic [3:0]  end_bus;
    logic [31:0] rd_base, wr_base, exp_ad;
    string       nm;
    nm = $sformatf("v%0d", vi);
    edges = 0; aslow = 0; blast = 0; pulses = 0; widx = 0; rdk = 0; guard = 0;
    acc = 0; acc_next = 0; fin = 0; t1_ok = 1; data_ok = 1; lock_ok = 1; derr = 0;
    dcnt = '0; end_bus = '0;
    wait_left = v.waits;
    rd_base = 32'h5A00_0000 | 32'(vi << 8);
    wr_base = 32'hC0DE_0000 | 32'(vi << 8);
    exp_ad  = v.addr & 32'hFFFF_FFFC;
    @(negedge clk2);
    wr_data = wr_base; ad_in = rd_base;
    req_valid = 1'b1; req_write = v.wr; req_addr = v.addr; req_len = v.len; req_be_n = v.be;
    while (!fin && guard < 400) begin
      if (!acc && !acc_next && req_valid && req_ready && pclk) acc_next = 1;
      if (!den_n && pclk) begin
        if (wait_left > 0) begin
          ready_n = 1'b1;
          wait_left--;
        end else begin
          ready_n = 1'b0;
          wait_left = v.waits;
          if (v.wr) data_ok &= (ad_out === (wr_base | 32'(widx))) && ad_oe;
          else      data_ok &= !ad_oe;
        end
      end else begin
        // low between PCLK edges in T2 must be ignored
        ready_n = den_n;
      end
      @(negedge clk2);
      guard++;
      if (acc) edges++;
      if (acc_next) begin acc = 1; acc_next = 0; req_valid = 1'b0; end
      if (!as_n) begin
        aslow++;
        t1_ok &= ad_oe && (ad_out === exp_ad) && (w_rn === v.wr) && (dt_rn === v.wr)
                 && (be_n === v.be) && den_n;
      end
      if (!blast_n) blast++;
      if (!lock_n || !inta_n) lock_ok = 0;
      if (rd_valid) begin
        pulses++;
        data_ok &= !v.wr && (rd_data === (rd_base | 32'(rdk)));
        rdk++;
        ad_in = rd_base | 32'(rdk);
      end
      if (wr_take) begin
        pulses++;
        data_ok &= v.wr;
        widx++;
        wr_data = wr_base | 32'(widx);
      end
      if (done) begin
        fin = 1; dcnt = done_cnt; derr = done_err;
        end_bus = {as_n, den_n, blast_n, ad_oe};
      end
    end
    ready_n = 1'b1;
    check({nm, "_finished"}, 64'(fin), 64'(1));
    check({nm, "_done_cnt"}, 64'(dcnt), 64'(v.exp_cnt));
    check({nm, "_done_err"}, 64'(derr), 64'(v.exp_err));
    check({nm, "_clk2_edges"}, 64'(edges), 64'(v.exp_edges));
    check({nm, "_as_low"}, 64'(aslow), 64'(v.exp_aslow));
    check({nm, "_blast_low"}, 64'(blast), 64'(v.exp_blast));
    check({nm, "_pulses"}, 64'(pulses), 64'(v.exp_pulses));
    check({nm, "_t1_bus"}, 64'(t1_ok), 64'(1));
    check({nm, "_data"}, 64'(data_ok), 64'(1));
    check({nm, "_end_bus"}, 64'(end_bus), 64'(4'b1110));
    check({nm, "_lock_inta"}, 64'(lock_ok), 64'(1));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation still running at %0t, required finish earlier", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t rec;
    int   guard;
    logic seen;
    //             wr    addr          len   be    waits cnt   err   edges aslow blast pulses
    vecs[0] = '{1'b0, 32'h4000_0010, 2'd0, 4'h0, 0,  3'd1, 1'b0, 4,    2,    4,    1};
    vecs[1] = '{1'b1, 32'h4000_0000, 2'd3, 4'h0, 0,  3'd4, 1'b0, 10,   2,    2,    4};
    vecs[2] = '{1'b0, 32'h4000_000C, 2'd3, 4'hC, 0,  3'd1, 1'b0, 4,    2,    4,    1};
    vecs[3] = '{1'b0, 32'h4000_0020, 2'd1, 4'h0, 3,  3'd2, 1'b0, 18,   2,    8,    2};
    vecs[4] = '{1'b0, 32'h4000_0030, 2'd0, 4'h0, 15, 3'd0, 1'b1, 10,   2,    10,   0};
    vecs[5] = '{1'b1, 32'h8000_0008, 2'd3, 4'h3, 0,  3'd2, 1'b0, 6,    2,    2,    2};
    vecs[6] = '{1'b1, 32'h4000_0104, 2'd2, 4'h9, 1,  3'd3, 1'b0, 14,   2,    4,    3};

    reset_async_n = 1'b0;
    req_valid = 1'b0; req_write = 1'b0; req_addr = '0; req_len = '0; req_be_n = 4'hF;
    wr_data = '0; ad_in = '0; ready_n = 1'b1;
    #12;
    check_reset_vals("por");
    @(negedge clk2);
    reset_async_n = 1'b1;

    for (int i = 0; i < 7; i++) run_txn(vecs[i], i);

    // Mid-burst reset: kill a 4-word write during its second T2.
    @(negedge clk2);
    req_valid = 1'b1; req_write = 1'b1; req_addr = 32'h4000_0000; req_len = 2'd3; req_be_n = 4'h0;
    wr_data = 32'hBEEF_0000; ready_n = 1'b0;
    guard = 0; seen = 0;
    while (!seen && guard < 60) begin
      @(negedge clk2);
      guard++;
      if (!as_n) req_valid = 1'b0;
      if (wr_take) seen = 1;
    end
    check("midburst_second_t2", 64'({seen, den_n}), 64'(2'b10));
    #2;
    reset_async_n = 1'b0;
    #1;
    check_reset_vals("midburst");
    ready_n = 1'b1; req_valid = 1'b0;
    guard = 0; seen = 0;
    repeat (4) begin
      @(negedge clk2);
      if (done || as_n !== 1'b1) seen = 1;
    end
    check("held_reset_quiet", 64'(seen), 64'(0));
    reset_async_n = 1'b1;

    rec = '{1'b1, 32'h4000_0004, 2'd0, 4'h5, 0, 3'd1, 1'b0, 4, 2, 4, 1};
    run_txn(rec, 7);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/i960_bus_master.md
# i960_bus_master

Synthesizable initiator for the i960 Sx local bus that issues single and burst read/write transactions on behalf of an on-board requester, such as a DMA or test engine. It sits on the same multiplexed bus as the existing address-decode/ready controller and drives the signals that controller consumes: `as_n`, `den_n`, `w_rn`, `dt_rn`, `blast_n`, `lock_n`, `inta_n`, and address/data. It terminates each data cycle on `ready_n`.

## Interface
Parameters:
- `TIMEOUT`, default 255: PCLK cycles one T2 may wait for `ready_n` before the access is aborted. Legal range 1..255.
- `IDLE_MIN`, default 1: minimum Ti PCLK cycles between transactions.

Ports:
- `clk2`  in  1  bus clock, 2x PCLK; all logic is on the rising edge.
- `reset_async_n`  in  1  asynchronous, active-low reset.
- `pclk`  out  1  internal PCLK phase; toggles every `clk2`.
- `req_valid`  in  1  transaction request.
- `req_ready`  out  1  request accepted when both `req_valid` and `req_ready` are high on a `clk2` edge with `pclk`=1.
- `req_write`  in  1  1 = write, 0 = read.
- `req_addr`  in  32  word address; bits [1:0] are ignored.
- `req_len`  in  2  number of words minus 1.
- `req_be_n`  in  4  byte enables, applied to every word.
- `wr_data`  in  32  write data for the current word.
- `wr_take`  out  1  one-`clk2` pulse when `wr_data` has been consumed; the requester presents the next word on the following edge.
- `rd_data`  out  32  captured read word.
- `rd_valid`  out  1  one-`clk2` pulse per captured word.
- `done`  out  1  one-`clk2` pulse at transaction end.
- `done_err`  out  1  valid with `done`; 1 = timeout abort.
- `done_cnt`  out  3  valid with `done`; number of words completed.
- `ad_out`  out  32  multiplexed address/data out.
- `ad_oe`  out  1  drive enable for `ad_out`.
- `ad_in`  in  32  multiplexed bus in.
- `be_n`  out  4  byte enables.
- `as_n`, `den_n`, `w_rn`, `dt_rn`, `blast_n`, `lock_n`, `inta_n`  out  1 each  i960 bus controls.
- `ready_n`  in  1  data-cycle termination from the system controller.

## Operation
- **PCLK phases:**
  - `pclk` toggles every `clk2`.
  - A "PCLK edge" is a `clk2` edge with `pclk`=1.
  - The FSM advances only on PCLK edges.
- **FSM states:** IDLE(Ti), T1, T2.
- **IDLE:**
  - `req_ready`=1 once `IDLE_MIN` Ti cycles have elapsed.
  - On accept: latch the request and compute `nwords` = min(`req_len`+1, 4 − `req_addr`[3:2]). Bursts never cross a 16-byte boundary, so longer requests are truncated.
  - Then go to T1.
- **T1 (exactly one PCLK cycle):**
  - `as_n`=0.
  - `ad_out`={addr[31:2],2'b00}, `ad_oe`=1.
  - `w_rn`=`dt_rn`=`req_write`; `be_n`=`req_be_n`.
  - `blast_n`=0 if `nwords`=1.
- **T2 (repeats):**
  - `as_n`=1, `den_n`=0.
  - Write: `ad_out`=`wr_data`, `ad_oe`=1. Read: `ad_oe`=0.
  - `blast_n`=0 during the T2 of the final word, 1 otherwise.
  - `ready_n` is sampled on every PCLK edge in T2.
  - **`ready_n`=1:** stay in T2 and increment the wait counter.
  - **`ready_n`=0:**
    - Read: capture `ad_in` into `rd_data` and pulse `rd_valid`.
    - Write: pulse `wr_take`.
    - Clear the wait counter and increment the word counter.
    - If this was the last word: `den_n`=1, `blast_n`=1, `ad_oe`=0, pulse `done` (`done_err`=0, `done_cnt`=`nwords`), go to IDLE.
    - Otherwise stay in T2 with the next word; the internal address increments addr[3:2] only.
  - **Wait counter reaches `TIMEOUT`:** abort to IDLE with the same deassertions, pulse `done` with `done_err`=1 and `done_cnt`=words completed. No `rd_valid` or `wr_take` is issued for the aborted word.
- **Fixed outputs:** `lock_n`=1 and `inta_n`=1 always; interrupt-acknowledge cycles are never issued.
- **Reset:** asynchronous assertion at any point, including mid-burst, immediately forces these values:
  - Control/strobe outputs: `as_n`=1, `den_n`=1, `blast_n`=1, `w_rn`=0, `dt_rn`=0, `ad_oe`=0, `be_n`=4'hF.
  - Outputs and pulses: `ad_out`=0, `pclk`=0, `req_ready`=0, `rd_valid`=0, `wr_take`=0, `done`=0, `done_err`=0, `done_cnt`=0, `rd_data`=0.
  - FSM and counters: IDLE, all counters 0.
  - No `done` pulse is issued for the killed transaction.

## Timing
- Control outputs are registered and change only on PCLK edges.
- The `rd_valid`, `wr_take` and `done` pulses occur on the PCLK edge itself and last one `clk2`.
- **Request to `as_n` low:** 1 `clk2` after acceptance; T1 lasts 2 `clk2`.
- **Zero-wait transfer:** T1 + one T2 per word, i.e. 4 `clk2` for a single word and 10 `clk2` for a 4-word burst.
- **Back-to-back transactions:** at least `IDLE_MIN` Ti PCLK cycles between the last T2 and the next T1.
- `ready_n` is sampled only on PCLK edges in T2; a low pulse on `ready_n` between PCLK edges is ignored.
- `done`, `rd_valid` and `wr_take` coincide on the final word.

## Structure
- Shared package `i960_bus_pkg` holds:
  - the bus-state encoding (UNKNOWN/Ti/T1/T2), shared with the system controller;
  - the address-area constants (ROM 2'b00, RAM 2'b01, MFP bit31=1).
- Natural sub-module: `i960_wait_timer`, the per-T2 wait counter with terminal-count output.
- Everything else lives in the top FSM.

## Test plan
- **Single read:** addr=0x4000_0010, len=0, `ready_n` low on the first T2 → `as_n` low for 2 `clk2`; `blast_n` low in T2; `rd_data`=`ad_in`; `done_cnt`=1; 4 `clk2` total.
- **4-word write burst:** addr=0x4000_0000, `ready_n` held low → 4 `wr_take` pulses 2 `clk2` apart; `blast_n` low only in the 4th T2; `done_cnt`=4.
- **Boundary truncation:** addr=0x4000_000C, len=3 → `nwords`=1; `done_cnt`=1.
- **Wait states:** read with `ready_n` high for 3 PCLK cycles per word, then low → 3 extra T2 cycles per word; `done_err`=0.
- **Timeout:** `TIMEOUT`=4, `ready_n` stuck high → abort after 4 T2 PCLK cycles; `done_err`=1; `done_cnt`=0; `den_n`=1.
- **Mid-burst reset:** assert `reset_async_n` low during the 2nd T2 → all outputs take their reset values within the same `clk2` cycle; after release the next request starts cleanly with T1.
